ng_time_pulse_gen: RTL

Time pulse generator that steps the twelve-pulse memory cycle (TP1..TP12) consumed by the control pulse decoder. The decoder combines the time-pulse code with the sequence generator's SQ, STB, BR1/BR2 and SNI outputs. The block also handles power-on, single-step (standby release / wait) and a memory-busy hold. It sits directly upstream of the sequence generator: every CP pulse that clocks SEQ is qualified by the TPG code produced here.

---
 rtl/ng_time_pulse_gen.sv | 100 ++++++++++
 1 files changed

// File: rtl/ng_time_pulse_gen.sv
// Time pulse generator: steps the TP1..TP12 memory cycle with power-on,
// single-step release and memory-busy hold at TP6.
module ng_time_pulse_gen #(
   parameter int unsigned PWRON_CYCLES = 4,
   parameter int unsigned MCT_W        = 16
) (
   input  logic             CLK2,
   input  logic             GENRST,
   input  logic             START,
   input  logic             RUN,
   input  logic             STEP,
   input  logic             MEM_BUSY,
   output logic [3:0]       TPG,
   output logic             TP12_PULSE,
   output logic             STALLED,
   output logic [MCT_W-1:0] MCT_CNT
);

   typedef enum logic [3:0] {
      ST_STBY  = 4'd0,
      ST_PWRON = 4'd1,
      ST_TP1   = 4'd2,
      ST_TP2   = 4'd3,
      ST_TP3   = 4'd4,
      ST_TP4   = 4'd5,
      ST_TP5   = 4'd6,
      ST_TP6   = 4'd7,
      ST_TP7   = 4'd8,
      ST_TP8   = 4'd9,
      ST_TP9   = 4'd10,
      ST_TP10  = 4'd11,
      ST_TP11  = 4'd12,
      ST_TP12  = 4'd13,
      ST_SRLSE = 4'd14,
      ST_WAIT  = 4'd15
   } tp_state_e;

   localparam logic [7:0]       PWRON_LAST = 8'(PWRON_CYCLES - 1);
   localparam logic [MCT_W-1:0] MCT_ONE    = {{(MCT_W-1){1'b0}}, 1'b1};

   tp_state_e  state;
   tp_state_e  state_nxt;
   logic [7:0] pwron_cnt;
   logic       step_q;

   always_ff @(posedge CLK2) begin
      if (!GENRST) begin
         state <= ST_STBY;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge CLK2) begin
      if (!GENRST) begin
         pwron_cnt <= '0;
         step_q    <= 1'b0;
         MCT_CNT   <= '0;
      end else begin
         step_q <= STEP;
         if (state == ST_STBY) begin
            pwron_cnt <= '0;
         end else if (state == ST_PWRON && START) begin
            pwron_cnt <= pwron_cnt + 8'd1;
         end
         // A cycle only counts as completed when it leaves TP12 normally.
         if (state == ST_TP12 && START) begin
            MCT_CNT <= MCT_CNT + MCT_ONE;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      if (!START) begin
         state_nxt = ST_STBY;
      end else begin
         case (state)
            ST_STBY:  state_nxt = ST_PWRON;
            ST_PWRON: if (pwron_cnt == PWRON_LAST) state_nxt = ST_TP1;
            ST_TP1, ST_TP2, ST_TP3, ST_TP4, ST_TP5,
            ST_TP7, ST_TP8, ST_TP9, ST_TP10, ST_TP11:
               state_nxt = tp_state_e'(state + 4'd1);
            ST_TP6:   if (!MEM_BUSY) state_nxt = ST_TP7;
            ST_TP12:  state_nxt = RUN ? ST_TP1 : ST_SRLSE;
            // Requiring STEP low first stops a held step releasing repeatedly.
            ST_SRLSE: if (!STEP) state_nxt = ST_WAIT;
            ST_WAIT:  if (RUN || (STEP && !step_q)) state_nxt = ST_TP1;
            default:  state_nxt = ST_STBY;
         endcase
      end
   end

   always_comb begin
      TPG        = state;
      TP12_PULSE = (state == ST_TP12);
      STALLED    = (state == ST_TP6) && MEM_BUSY;
   end

endmodule
